interrupt_ack_sequencer: RTL and testbench

INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

---
 rtl/interrupt_ack_sequencer.sv | 149 ++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ack_sequencer.sv
// 8259A-style two-pulse interrupt acknowledge sequencer (8086 mode).
// Selects the winning request, tracks the in-service register and drives the vector byte.
module interrupt_ack_sequencer #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi_config,
  input  logic [7:0] end_of_interrupt,
  output logic       interrupt_out,
  output logic       freeze,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] data_bus_out,
  output logic       data_bus_out_enable
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST_ACK,
    WAIT_SECOND,
    SECOND_ACK
  } state_t;

  state_t     state_q;
  logic       inta_q;
  logic [2:0] ack_level_q;
  logic       spurious_q;
  logic       int_q;
  logic       freeze_q;
  logic [7:0] clr_q;
  logic [7:0] isr_q;
  logic [7:0] isr_d;
  logic [7:0] dbo_q;
  logic       dbo_en_q;

  logic [7:0] pending;
  logic [2:0] pendIdx;
  logic       pendAny;
  logic [3:0] isrIdx;
  logic       qualifies;
  logic       fallEdge;
  logic       riseEdge;
  logic [7:0] isrSet;
  logic [7:0] isrClr;

  assign fallEdge = inta_q & ~interrupt_acknowledge_n;
  assign riseEdge = ~inta_q & interrupt_acknowledge_n;

  // Lowest pending level must beat the lowest in-service level; an empty ISR reads as level 8.
  always_comb begin
    pending = interrupt_request_register & ~interrupt_mask;
    pendIdx = 3'd0;
    pendAny = 1'b0;
    isrIdx  = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) begin
        pendIdx = 3'(i);
        pendAny = 1'b1;
      end
      if (isr_q[i]) begin
        isrIdx = 4'(i);
      end
    end
    qualifies = pendAny && ({1'b0, pendIdx} < isrIdx);
  end

  // A set from a new acknowledge overrides a simultaneous EOI clear of the same bit.
  always_comb begin
    isrSet = 8'h00;
    isrClr = end_of_interrupt;
    if (state_q == IDLE && fallEdge && qualifies) begin
      isrSet = 8'h01 << pendIdx;
    end
    if (state_q == SECOND_ACK && riseEdge && auto_eoi_config && !spurious_q) begin
      isrClr = isrClr | (8'h01 << ack_level_q);
    end
    isr_d = (isr_q & ~isrClr) | isrSet;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      inta_q      <= 1'b1;
      ack_level_q <= 3'd0;
      spurious_q  <= 1'b0;
      int_q       <= 1'b0;
      freeze_q    <= 1'b0;
      clr_q       <= 8'h00;
      isr_q       <= 8'h00;
      dbo_q       <= 8'h00;
      dbo_en_q    <= 1'b0;
    end else begin
      inta_q <= interrupt_acknowledge_n;
      clr_q  <= 8'h00;
      isr_q  <= isr_d;
      unique case (state_q)
        IDLE: begin
          if (fallEdge) begin
            ack_level_q <= qualifies ? pendIdx : SPURIOUS_LEVEL;
            spurious_q  <= ~qualifies;
            clr_q       <= qualifies ? (8'h01 << pendIdx) : 8'h00;
            freeze_q    <= 1'b1;
            int_q       <= 1'b0;
            state_q     <= FIRST_ACK;
          end else begin
            int_q <= qualifies;
          end
        end
        FIRST_ACK: begin
          // Bus stays floated on the first pulse in 8086 mode.
          dbo_en_q <= 1'b0;
          if (riseEdge) begin
            state_q <= WAIT_SECOND;
          end
        end
        WAIT_SECOND: begin
          if (fallEdge) begin
            dbo_q    <= {vector_base, ack_level_q};
            dbo_en_q <= 1'b1;
            state_q  <= SECOND_ACK;
          end
        end
        SECOND_ACK: begin
          if (riseEdge) begin
            dbo_en_q <= 1'b0;
            freeze_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign interrupt_out           = int_q;
  assign freeze                  = freeze_q;
  assign clear_interrupt_request = clr_q;
  assign in_service_register     = isr_q;
  assign data_bus_out            = dbo_q;
  assign data_bus_out_enable     = dbo_en_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer: directed vector table, corner sequences
// and a randomized run against a pulse-counting reference model.
module tb_interrupt_ack_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       intaN = 1'b1;
  logic [7:0] irr = 8'h00;
  logic [7:0] mask = 8'h00;
  logic [4:0] vectorBase = 5'd0;
  logic       autoEoi = 1'b0;
  logic [7:0] eoi = 8'h00;
  logic       interruptOut;
  logic       freezeOut;
  logic [7:0] clearIrr;
  logic [7:0] isrOut;
  logic [7:0] dataBus;
  logic       dataBusEn;

  int checks = 0;
  int errors = 0;

  interrupt_ack_sequencer dut (
    .clock                     (clock),
    .reset                     (reset),
    .interrupt_acknowledge_n   (intaN),
    .interrupt_request_register(irr),
    .interrupt_mask            (mask),
    .vector_base               (vectorBase),
    .auto_eoi_config           (autoEoi),
    .end_of_interrupt          (eoi),
    .interrupt_out             (interruptOut),
    .freeze                    (freezeOut),
    .clear_interrupt_request   (clearIrr),
    .in_service_register       (isrOut),
    .data_bus_out              (dataBus),
    .data_bus_out_enable       (dataBusEn)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pin;
    logic [7:0]  irr;
    logic [7:0]  mask;
    logic [4:0]  vb;
    logic        aeoi;
    logic [7:0]  eoi;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: acknowledge progress counted as pulse stage 0..3.
  logic       mPrev;
  int         mStage;
  int         mLevel;
  logic       mSpur;
  logic       mInt;
  logic       mFreeze;
  logic [7:0] mClr;
  logic [7:0] mIsr;
  logic [7:0] mDbo;
  logic       mEn;

  function automatic logic [26:0] pack(input logic i, input logic f, input logic [7:0] c,
                                       input logic [7:0] s, input logic [7:0] d, input logic e);
    return {i, f, c, s, d, e};
  endfunction

  function automatic vec_t mkVec(input logic pin, input logic [7:0] r, input logic [7:0] m,
                                 input logic [4:0] vb, input logic ae, input logic [7:0] eo,
                                 input logic [26:0] exp);
    vec_t v;
    v.pin = pin; v.irr = r; v.mask = m; v.vb = vb; v.aeoi = ae; v.eoi = eo; v.exp = exp;
    return v;
  endfunction

  function automatic logic [26:0] dutOut();
    return {interruptOut, freezeOut, clearIrr, isrOut, dataBus, dataBusEn};
  endfunction

  // Walk levels from highest priority; an in-service level reached first blocks everything below.
  function automatic int winner(input logic [7:0] r, input logic [7:0] m, input logic [7:0] s);
    for (int i = 0; i < 8; i++) begin
      if (s[i]) return -1;
      if (r[i] && !m[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mPrev = 1'b1; mStage = 0; mLevel = 0; mSpur = 1'b0; mInt = 1'b0;
    mFreeze = 1'b0; mClr = 8'h00; mIsr = 8'h00; mDbo = 8'h00; mEn = 1'b0;
  endtask

  task automatic modelStep(input logic pin, input logic [7:0] r, input logic [7:0] m,
                           input logic [4:0] vb, input logic ae, input logic [7:0] eo);
    logic fall, rise;
    logic [7:0] setB, clrB;
    int w;
    fall = mPrev && !pin;
    rise = !mPrev && pin;
    mPrev = pin;
    w = winner(r, m, mIsr);
    setB = 8'h00;
    clrB = 8'h00;
    mClr = 8'h00;
    if (mStage == 0) begin
      if (fall) begin
        mSpur = (w < 0);
        mLevel = (w < 0) ? 7 : w;
        if (w >= 0) begin
          setB = 8'h01 << w;
          mClr = setB;
        end
        mFreeze = 1'b1;
        mInt = 1'b0;
        mStage = 1;
      end else begin
        mInt = (w >= 0);
      end
    end else if (mStage == 1) begin
      if (rise) mStage = 2;
    end else if (mStage == 2) begin
      if (fall) begin
        mDbo = {vb, 3'(mLevel)};
        mEn = 1'b1;
        mStage = 3;
      end
    end else begin
      if (rise) begin
        mEn = 1'b0;
        mFreeze = 1'b0;
        if (ae && !mSpur) clrB = 8'h01 << mLevel;
        mStage = 0;
      end
    end
    mIsr = (mIsr & ~eo & ~clrB) | setB;
  endtask

  task automatic checkOutput(input string name, input logic [26:0] got, input logic [26:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got int=%b frz=%b clr=%h isr=%h dbo=%h en=%b required int=%b frz=%b clr=%h isr=%h dbo=%h en=%b",
               name, got[26], got[25], got[24:17], got[16:9], got[8:1], got[0],
               exp[26], exp[25], exp[24:17], exp[16:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic applyStimulus(input logic pin, input logic [7:0] r, input logic [7:0] m,
                               input logic [4:0] vb, input logic ae, input logic [7:0] eo);
    intaN = pin; irr = r; mask = m; vectorBase = vb; autoEoi = ae; eoi = eo;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    @(negedge clock);
    intaN = 1'b1; irr = 8'h00; mask = 8'h00; eoi = 8'h00; autoEoi = 1'b0;
    reset = 1'b1;
    #2;
    checkOutput("resetState", dutOut(), 27'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic pin;
    logic [7:0] r, m, eo;
    logic [4:0] vb;
    logic ae;

    // Basic acknowledge with auto-EOI.
    vecs.push_back(mkVec(1, 8'h08, 8'h00, 5'h04, 1, 8'h00, pack(1, 0, 8'h00, 8'h00, 8'h00, 0)));
    vecs.push_back(mkVec(0, 8'h08, 8'h00, 5'h04, 1, 8'h00, pack(0, 1, 8'h08, 8'h08, 8'h00, 0)));
    vecs.push_back(mkVec(0, 8'h00, 8'h00, 5'h04, 1, 8'h00, pack(0, 1, 8'h00, 8'h08, 8'h00, 0)));
    vecs.push_back(mkVec(1, 8'h00, 8'h00, 5'h04, 1, 8'h00, pack(0, 1, 8'h00, 8'h08, 8'h00, 0)));
    vecs.push_back(mkVec(0, 8'h00, 8'h00, 5'h04, 1, 8'h00, pack(0, 1, 8'h00, 8'h08, 8'h23, 1)));
    vecs.push_back(mkVec(1, 8'h00, 8'h00, 5'h04, 1, 8'h00, pack(0, 0, 8'h00, 8'h00, 8'h23, 0)));
    vecs.push_back(mkVec(1, 8'h00, 8'h00, 5'h04, 1, 8'h00, pack(0, 0, 8'h00, 8'h00, 8'h23, 0)));
    // Priority with IR1 masked.
    vecs.push_back(mkVec(1, 8'h06, 8'h02, 5'h04, 0, 8'h00, pack(1, 0, 8'h00, 8'h00, 8'h23, 0)));
    vecs.push_back(mkVec(0, 8'h06, 8'h02, 5'h04, 0, 8'h00, pack(0, 1, 8'h04, 8'h04, 8'h23, 0)));
    vecs.push_back(mkVec(0, 8'h02, 8'h02, 5'h04, 0, 8'h00, pack(0, 1, 8'h00, 8'h04, 8'h23, 0)));
    vecs.push_back(mkVec(1, 8'h02, 8'h02, 5'h04, 0, 8'h00, pack(0, 1, 8'h00, 8'h04, 8'h23, 0)));
    vecs.push_back(mkVec(0, 8'h02, 8'h02, 5'h04, 0, 8'h00, pack(0, 1, 8'h00, 8'h04, 8'h22, 1)));
    vecs.push_back(mkVec(1, 8'h02, 8'h02, 5'h04, 0, 8'h00, pack(0, 0, 8'h00, 8'h04, 8'h22, 0)));
    // Nesting: IR4 blocked by IR2 in service, IR0 nests.
    vecs.push_back(mkVec(1, 8'h10, 8'h00, 5'h04, 0, 8'h00, pack(0, 0, 8'h00, 8'h04, 8'h22, 0)));
    vecs.push_back(mkVec(1, 8'h10, 8'h00, 5'h04, 0, 8'h00, pack(0, 0, 8'h00, 8'h04, 8'h22, 0)));
    vecs.push_back(mkVec(1, 8'h01, 8'h00, 5'h04, 0, 8'h00, pack(1, 0, 8'h00, 8'h04, 8'h22, 0)));
    vecs.push_back(mkVec(0, 8'h01, 8'h00, 5'h04, 0, 8'h00, pack(0, 1, 8'h01, 8'h05, 8'h22, 0)));
    vecs.push_back(mkVec(0, 8'h00, 8'h00, 5'h04, 0, 8'h00, pack(0, 1, 8'h00, 8'h05, 8'h22, 0)));
    vecs.push_back(mkVec(1, 8'h00, 8'h00, 5'h04, 0, 8'h00, pack(0, 1, 8'h00, 8'h05, 8'h22, 0)));
    vecs.push_back(mkVec(0, 8'h00, 8'h00, 5'h04, 0, 8'h00, pack(0, 1, 8'h00, 8'h05, 8'h20, 1)));
    vecs.push_back(mkVec(1, 8'h00, 8'h00, 5'h04, 0, 8'h00, pack(0, 0, 8'h00, 8'h05, 8'h20, 0)));
    vecs.push_back(mkVec(1, 8'h00, 8'h00, 5'h04, 0, 8'h05, pack(0, 0, 8'h00, 8'h00, 8'h20, 0)));
    // Spurious: request withdrawn before the first falling edge.
    vecs.push_back(mkVec(1, 8'h08, 8'h00, 5'h04, 0, 8'h00, pack(1, 0, 8'h00, 8'h00, 8'h20, 0)));
    vecs.push_back(mkVec(1, 8'h00, 8'h00, 5'h04, 0, 8'h00, pack(0, 0, 8'h00, 8'h00, 8'h20, 0)));
    vecs.push_back(mkVec(0, 8'h00, 8'h00, 5'h04, 0, 8'h00, pack(0, 1, 8'h00, 8'h00, 8'h20, 0)));
    vecs.push_back(mkVec(1, 8'h00, 8'h00, 5'h04, 0, 8'h00, pack(0, 1, 8'h00, 8'h00, 8'h20, 0)));
    vecs.push_back(mkVec(0, 8'h00, 8'h00, 5'h04, 0, 8'h00, pack(0, 1, 8'h00, 8'h00, 8'h27, 1)));
    vecs.push_back(mkVec(1, 8'h00, 8'h00, 5'h04, 1, 8'h00, pack(0, 0, 8'h00, 8'h00, 8'h27, 0)));

    doReset();
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].pin, vecs[k].irr, vecs[k].mask, vecs[k].vb, vecs[k].aeoi, vecs[k].eoi);
      checkOutput($sformatf("vec%0d", k), dutOut(), vecs[k].exp);
    end

    // EOI colliding with the ISR set, then reset while in SECOND_ACK.
    doReset();
    applyStimulus(1, 8'h08, 8'h00, 5'h04, 0, 8'h00);
    checkOutput("collideIdle", dutOut(), pack(1, 0, 8'h00, 8'h00, 8'h00, 0));
    applyStimulus(0, 8'h08, 8'h00, 5'h04, 0, 8'h08);
    checkOutput("collideSetWins", dutOut(), pack(0, 1, 8'h08, 8'h08, 8'h00, 0));
    applyStimulus(0, 8'h00, 8'h00, 5'h04, 0, 8'h00);
    applyStimulus(1, 8'h00, 8'h00, 5'h04, 0, 8'h00);
    applyStimulus(0, 8'h00, 8'h00, 5'h04, 0, 8'h00);
    checkOutput("secondAck", dutOut(), pack(0, 1, 8'h00, 8'h08, 8'h23, 1));
    reset = 1'b1;
    #1;
    checkOutput("midSeqReset", dutOut(), 27'd0);
    intaN = 1'b1;
    irr = 8'h02;
    #2;
    reset = 1'b0;
    applyStimulus(1, 8'h02, 8'h00, 5'h04, 0, 8'h00);
    checkOutput("postResetIdle", dutOut(), pack(1, 0, 8'h00, 8'h00, 8'h00, 0));
    applyStimulus(1, 8'h02, 8'h00, 5'h04, 0, 8'h00);
    checkOutput("postResetNoEdge", dutOut(), pack(1, 0, 8'h00, 8'h00, 8'h00, 0));
    applyStimulus(0, 8'h02, 8'h00, 5'h04, 0, 8'h00);
    checkOutput("postResetFirstAck", dutOut(), pack(0, 1, 8'h02, 8'h02, 8'h00, 0));

    // Randomized run against the reference model.
    doReset();
    modelReset();
    pin = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(2) == 0) pin = ~pin;
      r  = 8'($urandom & $urandom & $urandom);
      m  = 8'($urandom & $urandom);
      vb = 5'($urandom);
      ae = 1'($urandom);
      eo = ($urandom_range(7) == 0) ? (8'h01 << $urandom_range(7)) : 8'h00;
      modelStep(pin, r, m, vb, ae, eo);
      applyStimulus(pin, r, m, vb, ae, eo);
      checkOutput($sformatf("rand%0d", n), dutOut(), {mInt, mFreeze, mClr, mIsr, mDbo, mEn});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
